// File: rtl/cgra_clk_gate_ctrl_if.sv
// Bus between the enable/MMIO logic and the per-domain clock-enable controller.
// The controller connects as slave; whatever drives the run requests and OBI status connects as master.
interface cgra_clk_gate_ctrl_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int IDLE_CNT_W  = 8
);
    logic [NUM_DOMAINS-1:0] enable_i;
    logic [NUM_DOMAINS-1:0] wake_i;
    logic [NUM_DOMAINS-1:0] busy_i;
    logic [NUM_DOMAINS-1:0] obi_req_i;
    logic [NUM_DOMAINS-1:0] obi_gnt_i;
    logic [NUM_DOMAINS-1:0] obi_rvalid_i;
    logic [IDLE_CNT_W-1:0]  idle_thresh_i;
    logic [NUM_DOMAINS-1:0] clk_en_o;
    logic [NUM_DOMAINS-1:0] ready_o;
    logic                   err_o;

    modport master (
        output enable_i, wake_i, busy_i, obi_req_i, obi_gnt_i, obi_rvalid_i, idle_thresh_i,
        input  clk_en_o, ready_o, err_o
    );

    modport slave (
        input  enable_i, wake_i, busy_i, obi_req_i, obi_gnt_i, obi_rvalid_i, idle_thresh_i,
        output clk_en_o, ready_o, err_o
    );
endinterface

// File: rtl/cgra_clk_gate_ctrl.sv
// Per-domain clock-enable controller (OFF/WAKE/ON/DRAIN) that never gates a domain with OBI traffic in flight.
// Define CGRA_AUTO_GATE_EN to add idle auto-gating with wake_i wake-up.
module cgra_clk_gate_ctrl #(
    parameter int NUM_DOMAINS = 4,
    parameter int OUTST_W     = 3,
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    cgra_clk_gate_ctrl_if.slave bus
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_WAKE  = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int SETTLE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(WAKE_CYCLES - 1);
    localparam logic [OUTST_W-1:0]  OUTST_MAX   = '1;

    logic [NUM_DOMAINS-1:0] w_incErr;
    logic [NUM_DOMAINS-1:0] w_decErr;
    logic                   r_err;

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        logic [1:0]          r_state;
        logic [1:0]          w_next;
        logic [SETTLE_W-1:0] r_settle;
        logic [SETTLE_W-1:0] w_settleNext;
        logic [OUTST_W-1:0]  r_outst;
        logic                r_clkEn;
        logic                r_ready;
        logic                w_inc;
        logic                w_dec;
        logic                w_canWake;
        logic                w_autoGate;

        assign w_inc       = bus.obi_req_i[d] & bus.obi_gnt_i[d];
        assign w_dec       = bus.obi_rvalid_i[d];
        assign w_incErr[d] = w_inc & ~w_dec & (r_outst == OUTST_MAX);
        assign w_decErr[d] = w_dec & ~w_inc & (r_outst == '0);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_outst <= '0;
            end else if (w_inc & ~w_dec & ~w_incErr[d]) begin
                r_outst <= r_outst + 1'b1;
            end else if (w_dec & ~w_inc & ~w_decErr[d]) begin
                r_outst <= r_outst - 1'b1;
            end
        end

`ifdef CGRA_AUTO_GATE_EN
        logic [IDLE_CNT_W-1:0] r_idle;
        logic                  r_autoGated;
        logic                  w_idleNow;

        assign w_idleNow  = ~bus.busy_i[d] & ~bus.obi_req_i[d] & (r_outst == '0);
        assign w_autoGate = (bus.idle_thresh_i != '0) && (r_idle == bus.idle_thresh_i);
        assign w_canWake  = ~r_autoGated | bus.wake_i[d];

        // Idle count only accumulates while the domain stays ON; it saturates rather than wrapping.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_idle      <= '0;
                r_autoGated <= 1'b0;
            end else begin
                if (r_state != ST_ON || w_next != ST_ON || !w_idleNow) begin
                    r_idle <= '0;
                end else if (r_idle != '1) begin
                    r_idle <= r_idle + 1'b1;
                end

                if (!bus.enable_i[d]) begin
                    r_autoGated <= 1'b0;
                end else if (r_state == ST_ON && w_autoGate) begin
                    r_autoGated <= 1'b1;
                end else if (r_state == ST_OFF && w_canWake) begin
                    r_autoGated <= 1'b0;
                end
            end
        end
`else
        logic w_unused;

        assign w_unused   = bus.wake_i[d] ^ bus.busy_i[d] ^ (^bus.idle_thresh_i);
        assign w_autoGate = 1'b0;
        assign w_canWake  = 1'b1;
`endif

        always_comb begin
            w_next       = r_state;
            w_settleNext = r_settle;
            case (r_state)
                ST_OFF: begin
                    if (bus.enable_i[d] && w_canWake) begin
                        w_next       = ST_WAKE;
                        w_settleNext = '0;
                    end
                end
                ST_WAKE: begin
                    if (!bus.enable_i[d]) begin
                        w_next = ST_DRAIN;
                    end else if (r_settle == SETTLE_LAST) begin
                        w_next = ST_ON;
                    end else begin
                        w_settleNext = r_settle + 1'b1;
                    end
                end
                ST_ON: begin
                    if (!bus.enable_i[d] || w_autoGate) begin
                        w_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_outst == '0 && !bus.obi_req_i[d]) begin
                        w_next = ST_OFF;
                    end
                end
                default: w_next = ST_OFF;
            endcase
        end

        // Enables are flopped from the next state so the clock gate sees a glitch-free level.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state  <= ST_OFF;
                r_settle <= '0;
                r_clkEn  <= 1'b0;
                r_ready  <= 1'b0;
            end else begin
                r_state  <= w_next;
                r_settle <= w_settleNext;
                r_clkEn  <= (w_next != ST_OFF);
                r_ready  <= (w_next == ST_ON);
            end
        end

        assign bus.clk_en_o[d] = r_clkEn;
        assign bus.ready_o[d]  = r_ready;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if ((|w_incErr) || (|w_decErr)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_o = r_err;

endmodule

// File: tb/tb_cgra_clk_gate_ctrl.sv
// Self-checking bench for cgra_clk_gate_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of each domain's clock and outstanding count.
module tb_cgra_clk_gate_ctrl;

    localparam int ND = 4;
    localparam int OW = 3;
    localparam int IW = 8;
    localparam int WC = 2;
    localparam int OUT_MAX = (1 << OW) - 1;
    localparam int IDLE_MAX = (1 << IW) - 1;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;

    // Model: clock on/off, draining flag, cycles since clock turned on, outstanding count
    bit mEn[ND];
    bit mDrain[ND];
    bit mAuto[ND];
    int mAge[ND];
    int mOut[ND];
    int mIdle[ND];
    bit mErr;

    always #5 clk_i = ~clk_i;

    cgra_clk_gate_ctrl_if #(.NUM_DOMAINS(ND), .IDLE_CNT_W(IW)) bus ();

    cgra_clk_gate_ctrl #(
        .NUM_DOMAINS(ND),
        .OUTST_W    (OW),
        .IDLE_CNT_W (IW),
        .WAKE_CYCLES(WC)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cycle, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [ND-1:0] en, input logic [ND-1:0] req,
                                 input logic [ND-1:0] gnt, input logic [ND-1:0] rv);
        bus.enable_i     = en;
        bus.obi_req_i    = req;
        bus.obi_gnt_i    = gnt;
        bus.obi_rvalid_i = rv;
    endtask

    task automatic modelReset();
        for (int d = 0; d < ND; d++) begin
            mEn[d] = 0; mDrain[d] = 0; mAuto[d] = 0; mAge[d] = 0; mOut[d] = 0; mIdle[d] = 0;
        end
        mErr = 0;
    endtask

    function automatic logic [ND-1:0] expClkEn();
        logic [ND-1:0] v;
        for (int d = 0; d < ND; d++) v[d] = mEn[d];
        return v;
    endfunction

    function automatic logic [ND-1:0] expReady();
        logic [ND-1:0] v;
        for (int d = 0; d < ND; d++) v[d] = mEn[d] && !mDrain[d] && (mAge[d] >= WC);
        return v;
    endfunction

    task automatic modelStep();
        for (int d = 0; d < ND; d++) begin
            bit en = bus.enable_i[d];
            bit req = bus.obi_req_i[d];
            bit inc = bus.obi_req_i[d] & bus.obi_gnt_i[d];
            bit dec = bus.obi_rvalid_i[d];
            bit wasReady = mEn[d] && !mDrain[d] && (mAge[d] >= WC);
            bit trig = 0;
`ifdef CGRA_AUTO_GATE_EN
            trig = wasReady && en && (bus.idle_thresh_i != 0) && (mIdle[d] == int'(bus.idle_thresh_i));
            if (wasReady && en && !trig && !bus.busy_i[d] && !req && mOut[d] == 0)
                mIdle[d] = (mIdle[d] < IDLE_MAX) ? mIdle[d] + 1 : IDLE_MAX;
            else
                mIdle[d] = 0;
`endif
            if (!mEn[d]) begin
                if (en && (!mAuto[d] || bus.wake_i[d])) begin
                    mEn[d] = 1; mAge[d] = 0; mDrain[d] = 0; mAuto[d] = 0;
                end
            end else if (mDrain[d]) begin
                if (mOut[d] == 0 && !req) mEn[d] = 0;
            end else if (!en) begin
                mDrain[d] = 1;
            end else if (trig) begin
                mDrain[d] = 1; mAuto[d] = 1;
            end else if (mAge[d] < WC) begin
                mAge[d]++;
            end
            if (!en) mAuto[d] = 0;
            if (inc && !dec) begin
                if (mOut[d] == OUT_MAX) mErr = 1; else mOut[d]++;
            end else if (dec && !inc) begin
                if (mOut[d] == 0) mErr = 1; else mOut[d]--;
            end
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        modelStep();
        cycle++;
        @(negedge clk_i);
        checkOutput("clk_en", bus.clk_en_o, expClkEn());
        checkOutput("ready", bus.ready_o, expReady());
        checkOutput("err", bus.err_o, mErr);
    endtask

    task automatic applyReset();
        applyStimulus('0, '0, '0, '0);
        rst_ni = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_clken", bus.clk_en_o, '0);
        checkOutput("rst_ready", bus.ready_o, '0);
        checkOutput("rst_err", bus.err_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [ND-1:0] en;
        logic [ND-1:0] req;
        logic [ND-1:0] gnt;
        logic [ND-1:0] rv;
        bus.wake_i        = '0;
        bus.busy_i        = '0;
        bus.idle_thresh_i = '0;
        rst_ni            = 1'b0;
        @(negedge clk_i);
        applyReset();

        // Wake timing on domain 0
        applyStimulus(4'b0001, '0, '0, '0);
        stepCycle();
        checkOutput("wake_c1_clken", bus.clk_en_o, 4'b0001);
        checkOutput("wake_c1_ready", bus.ready_o, 4'b0000);
        stepCycle();
        checkOutput("wake_c2_ready", bus.ready_o, 4'b0000);
        stepCycle();
        checkOutput("wake_c3_ready", bus.ready_o, 4'b0001);

        // Drain with three transactions in flight
        applyStimulus(4'b0001, 4'b0001, 4'b0001, '0);
        repeat (3) stepCycle();
        applyStimulus('0, '0, '0, '0);
        stepCycle();
        checkOutput("drain_start_clken", bus.clk_en_o, 4'b0001);
        applyStimulus(4'b0001, '0, '0, 4'b0001);
        repeat (3) stepCycle();
        checkOutput("drain_rv3_clken", bus.clk_en_o, 4'b0001);
        applyStimulus(4'b0001, '0, '0, '0);
        stepCycle();
        checkOutput("drain_done_clken", bus.clk_en_o, 4'b0000);
        applyStimulus('0, '0, '0, '0);
        repeat (2) stepCycle();

        // Simultaneous grant and rvalid leaves the count at 2
        applyStimulus(4'b0001, '0, '0, '0);
        repeat (3) stepCycle();
        applyStimulus(4'b0001, 4'b0001, 4'b0001, '0);
        repeat (2) stepCycle();
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        stepCycle();
        applyStimulus('0, '0, '0, 4'b0001);
        repeat (2) stepCycle();
        checkOutput("same_cyc_rv2_clken", bus.clk_en_o, 4'b0001);
        applyStimulus('0, '0, '0, '0);
        stepCycle();
        checkOutput("same_cyc_off_clken", bus.clk_en_o, 4'b0000);
        checkOutput("same_cyc_err", bus.err_o, 1'b0);

        // Underflow error is sticky
        applyStimulus('0, '0, '0, 4'b0010);
        stepCycle();
        checkOutput("underflow_err", bus.err_o, 1'b1);
        applyStimulus('0, '0, '0, '0);
        stepCycle();
        checkOutput("underflow_sticky", bus.err_o, 1'b1);

        // Saturation after eight grants
        applyReset();
        applyStimulus('0, 4'b1000, 4'b1000, '0);
        repeat (7) stepCycle();
        checkOutput("sat7_err", bus.err_o, 1'b0);
        stepCycle();
        checkOutput("sat8_err", bus.err_o, 1'b1);
        applyReset();

`ifdef CGRA_AUTO_GATE_EN
        // Idle auto-gate, then hold OFF until wake_i
        bus.idle_thresh_i = 8'd5;
        applyStimulus(4'b0001, '0, '0, '0);
        repeat (12) stepCycle();
        checkOutput("auto_off_clken", bus.clk_en_o, 4'b0000);
        repeat (3) stepCycle();
        checkOutput("auto_hold_clken", bus.clk_en_o, 4'b0000);
        bus.wake_i = 4'b0001;
        stepCycle();
        bus.wake_i = '0;
        checkOutput("auto_wake_clken", bus.clk_en_o, 4'b0001);
        bus.idle_thresh_i = '0;
        applyReset();
`endif

        // Async reset while draining with count 2
        applyStimulus(4'b0001, '0, '0, '0);
        repeat (3) stepCycle();
        applyStimulus(4'b0001, 4'b0001, 4'b0001, '0);
        repeat (2) stepCycle();
        applyStimulus('0, '0, '0, '0);
        stepCycle();
        #2;
        rst_ni = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_clken", bus.clk_en_o, '0);
        checkOutput("async_rst_ready", bus.ready_o, '0);
        @(negedge clk_i);
        #3;
        rst_ni = 1'b1;
        @(negedge clk_i);
        repeat (3) stepCycle();
        checkOutput("post_rst_off", bus.clk_en_o, '0);
        applyStimulus(4'b0001, '0, '0, '0);
        stepCycle();
        checkOutput("post_rst_wake", bus.clk_en_o, 4'b0001);

        // Randomized traffic on all domains
        applyReset();
        en = '0;
        for (int i = 0; i < 3000; i++) begin
            bit quiet = ((i / 150) % 2) == 1;
            if (i % 400 == 0) bus.idle_thresh_i = ($urandom_range(1) == 0) ? IW'(0) : IW'($urandom_range(8, 2));
            for (int d = 0; d < ND; d++) begin
                if ($urandom_range(11) == 0) en[d] = ~en[d];
                req[d] = quiet ? ($urandom_range(15) == 0) : ($urandom_range(2) == 0);
                gnt[d] = $urandom_range(1);
                rv[d]  = (mOut[d] > 0 && $urandom_range(2) == 0) || ($urandom_range(299) == 0);
                bus.wake_i[d] = ($urandom_range(5) == 0);
                bus.busy_i[d] = quiet ? ($urandom_range(15) == 0) : ($urandom_range(1) == 0);
            end
            applyStimulus(en, req, gnt, rv);
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
